arb2to1: RTL and testbench
==========================

ARB2TO1 -- requirements
Module: arb2to1

Interface
REQ-001 The block SHALL have parameter: n, 32, data width of each requester and of the output.
REQ-002 The block SHALL have port: clk  input  1  single clock, all state on rising edge.
REQ-003 The block SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 The block SHALL have port: valid1  input  1  requester 1 holds data1.
REQ-005 The block SHALL have port: data1  input  n  requester 1 payload.
REQ-006 The block SHALL have port: ready1  output  1  requester 1 transfer accepted this cycle.
REQ-007 The block SHALL have port: valid2  input  1  requester 2 holds data2.
REQ-008 The block SHALL have port: data2  input  n  requester 2 payload.
REQ-009 The block SHALL have port: ready2  output  1  requester 2 transfer accepted this cycle.
REQ-010 The block SHALL have port: out_valid  output  1  out_data holds an unconsumed word.
REQ-011 The block SHALL have port: out_data  output  n  registered selected payload.
REQ-012 The block SHALL have port: out_sel  output  1  source of out_data: 0 = requester 1, 1 = requester 2.
REQ-013 The block SHALL have port: out_ready  input  1  consumer accepts out_data this cycle.

Function
REQ-014 States SHALL be EMPTY (output register free) and FULL (out_valid=1, awaiting out_ready).
REQ-015 Load condition SHALL be: state==EMPTY, or state==FULL with out_ready=1.
REQ-016 With load condition true and exactly one valid asserted, that requester SHALL be granted.
REQ-017 With load condition true and both valid asserted, the requester not granted last SHALL win (round-robin pointer ptr).
REQ-018 readyX SHALL be combinational: 1 only when load condition true and requester X granted; at most one ready per cycle.
REQ-019 On a handshake (validX & readyX), next edge SHALL load out_data=dataX, out_sel=X-1, out_valid=1, state=FULL, ptr toggled away from X.
REQ-020 In FULL with out_ready=1 and no valid input, next edge SHALL clear out_valid, state=EMPTY; out_data/out_sel hold.
REQ-021 In FULL with out_ready=0, out_data, out_sel, out_valid and ptr SHALL hold; ready1=ready2=0.
REQ-022 Latency SHALL be one cycle from input handshake to out_valid; sustained throughput one word per cycle.
REQ-023 Once granted a cycle's readiness, an input deasserting valid SHALL not change any state.

Reset
REQ-024 rst_n=0 SHALL asynchronously force state=EMPTY, out_valid=0, out_data=0, out_sel=0, ptr=requester 1 preferred.
REQ-025 Reset mid-transfer SHALL discard the held word; ready1/ready2 SHALL be 0 while rst_n=0.

Configuration
REQ-026 With macro ARB2TO1_CNT_EN defined, the block SHALL add outputs gnt_cnt1, gnt_cnt2 (16 bits each), counting handshakes per requester, saturating at 16'hFFFF, reset to 0.
REQ-027 Without ARB2TO1_CNT_EN, those ports and counters SHALL not exist; all other behaviour identical.

Structure
REQ-028 Package arb2to1_pkg SHALL hold the state enum typedef (EMPTY, FULL), SEL_D1=1'b0, SEL_D2=1'b1, and CNT_W=16.
REQ-029 Payload selection SHALL instantiate the existing mux2to1 sub-module (select = grant, data1, data2, dataOut to output register).

Verification
REQ-030 Reset then valid1=1, data1=32'h0000_0007, out_ready=1 -> ready1=1 same cycle; next cycle out_valid=1, out_data=7, out_sel=0.
REQ-031 valid1=valid2=1 (data1=1, data2=2) held, out_ready=1 for 4 cycles -> out_data sequence 1,2,1,2; out_sel 0,1,0,1.
REQ-032 valid2=1 data2=32'hAA, out_ready=0 for 3 cycles -> out_data=AA held, ready2=0 after first handshake, out_valid stays 1.
REQ-033 FULL state, out_ready=1, no valid -> next cycle out_valid=0, state EMPTY.
REQ-034 rst_n pulsed low while out_valid=1 -> out_valid=0, out_data=0 immediately, not waiting for clk.
REQ-035 ARB2TO1_CNT_EN defined, 5 requester-1 and 3 requester-2 handshakes -> gnt_cnt1=5, gnt_cnt2=3; forced to 16'hFFFF, one more handshake -> stays 16'hFFFF.

Source files
------------

// File: rtl/arb2to1_pkg.sv
// Shared types and constants for the two-requester round-robin arbiter.
// Optional grant counters are enabled by defining ARB2TO1_CNT_EN.
package arb2to1_pkg;

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } state_t;

  localparam logic SEL_D1 = 1'b0;
  localparam logic SEL_D2 = 1'b1;
  localparam int   CNT_W  = 16;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt);
    if (cnt == {CNT_W{1'b1}}) begin
      return cnt;
    end else begin
      return cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

endpackage

// File: rtl/arb2to1_if.sv
// Handshake bundle between two requesters, the arbiter and its consumer.
// The gnt_cnt1/gnt_cnt2 signals exist only when ARB2TO1_CNT_EN is defined.
interface arb2to1_if import arb2to1_pkg::*; #(parameter int n = 32);

  logic         valid1;
  logic [n-1:0] data1;
  logic         ready1;
  logic         valid2;
  logic [n-1:0] data2;
  logic         ready2;
  logic         out_valid;
  logic [n-1:0] out_data;
  logic         out_sel;
  logic         out_ready;
`ifdef ARB2TO1_CNT_EN
  logic [CNT_W-1:0] gnt_cnt1;
  logic [CNT_W-1:0] gnt_cnt2;
`endif

  modport master (
    output valid1, data1, valid2, data2, out_ready,
    input  ready1, ready2, out_valid, out_data, out_sel
`ifdef ARB2TO1_CNT_EN
    , input gnt_cnt1, gnt_cnt2
`endif
  );

  modport slave (
    input  valid1, data1, valid2, data2, out_ready,
    output ready1, ready2, out_valid, out_data, out_sel
`ifdef ARB2TO1_CNT_EN
    , output gnt_cnt1, gnt_cnt2
`endif
  );

endinterface

// File: rtl/mux2to1.sv
// Plain two-way payload selector: sel=0 picks data1, sel=1 picks data2.
module mux2to1 #(parameter int n = 32) (
  input  logic         sel,
  input  logic [n-1:0] data1,
  input  logic [n-1:0] data2,
  output logic [n-1:0] data_out
);

  // Select between the two payloads.
  always_comb begin
    if (sel) begin
      data_out = data2;
    end else begin
      data_out = data1;
    end
  end

endmodule

// File: rtl/arb2to1.sv
// Two-requester round-robin arbiter feeding a single registered output slot.
// Defining ARB2TO1_CNT_EN adds saturating per-requester handshake counters.
module arb2to1 import arb2to1_pkg::*; #(parameter int n = 32) (
  input  logic       clk,
  input  logic       rst_n,
  arb2to1_if.slave   bus
);

  state_t       state_r, state_s;
  logic         ptr_r, ptr_s;
  logic [n-1:0] data_r, data_s;
  logic         sel_r, sel_s;
  logic         load_s;
  logic         gnt_s;
  logic         ready1_s, ready2_s;
  logic         hs_s;
  logic [n-1:0] mux_out_s;

  mux2to1 #(.n(n)) u_mux (
    .sel      (gnt_s),
    .data1    (bus.data1),
    .data2    (bus.data2),
    .data_out (mux_out_s)
  );

  // Grant decision: a lone requester wins, a tie goes to the side ptr_r favours.
  always_comb begin
    load_s = 1'b0;
    gnt_s  = ptr_r;
    case (state_r)
      EMPTY:   load_s = 1'b1;
      FULL:    load_s = bus.out_ready;
      default: load_s = 1'b0;
    endcase
    if (bus.valid1 && !bus.valid2) begin
      gnt_s = SEL_D1;
    end else if (bus.valid2 && !bus.valid1) begin
      gnt_s = SEL_D2;
    end else begin
      gnt_s = ptr_r;
    end
    // rst_n gating keeps both readies low for the whole reset window.
    ready1_s = rst_n && load_s && bus.valid1 && (gnt_s == SEL_D1);
    ready2_s = rst_n && load_s && bus.valid2 && (gnt_s == SEL_D2);
    hs_s     = ready1_s || ready2_s;
  end

  // Next-state and output-register update.
  always_comb begin
    state_s = state_r;
    ptr_s   = ptr_r;
    data_s  = data_r;
    sel_s   = sel_r;
    if (hs_s) begin
      state_s = FULL;
      data_s  = mux_out_s;
      sel_s   = gnt_s;
      ptr_s   = ~gnt_s;
    end else if ((state_r == FULL) && bus.out_ready) begin
      state_s = EMPTY;
    end else begin
      state_s = state_r;
    end
  end

  // State, round-robin pointer and output slot registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= EMPTY;
      ptr_r   <= SEL_D1;
      data_r  <= {n{1'b0}};
      sel_r   <= SEL_D1;
    end else begin
      state_r <= state_s;
      ptr_r   <= ptr_s;
      data_r  <= data_s;
      sel_r   <= sel_s;
    end
  end

  assign bus.ready1    = ready1_s;
  assign bus.ready2    = ready2_s;
  assign bus.out_valid = (state_r == FULL);
  assign bus.out_data  = data_r;
  assign bus.out_sel   = sel_r;

`ifdef ARB2TO1_CNT_EN
  logic [CNT_W-1:0] cnt1_r;
  logic [CNT_W-1:0] cnt2_r;

  // Per-requester handshake counters, sticky at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt1_r <= {CNT_W{1'b0}};
      cnt2_r <= {CNT_W{1'b0}};
    end else begin
      if (ready1_s) begin
        cnt1_r <= sat_inc(cnt1_r);
      end
      if (ready2_s) begin
        cnt2_r <= sat_inc(cnt2_r);
      end
    end
  end

  assign bus.gnt_cnt1 = cnt1_r;
  assign bus.gnt_cnt2 = cnt2_r;
`endif

endmodule

// File: tb/tb_arb2to1.sv
// Scoreboard bench for arb2to1: directed scenarios plus a random back-to-back run.
// Counter checks are compiled in when ARB2TO1_CNT_EN is defined.
module tb_arb2to1;
  import arb2to1_pkg::*;

  localparam int N = 32;

  logic clk;
  logic rst_n;
  int   vec = 0;
  int   err = 0;

  logic [N:0] sb[$];
  logic [N:0] junk;
  logic       m_full;
  logic       m_ptr;
  logic       exp_r1;
  logic       exp_r2;

  arb2to1_if #(.n(N)) bus();

  arb2to1 #(.n(N)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic drive(input logic v1, input logic [N-1:0] d1,
                       input logic v2, input logic [N-1:0] d2, input logic ordy);
    logic load;
    logic gnt;
    bus.valid1    = v1;
    bus.data1     = d1;
    bus.valid2    = v2;
    bus.data2     = d2;
    bus.out_ready = ordy;
    load = !m_full || ordy;
    if (v1 && !v2)      gnt = 1'b0;
    else if (v2 && !v1) gnt = 1'b1;
    else                gnt = m_ptr;
    exp_r1 = load && v1 && !gnt;
    exp_r2 = load && v2 && gnt;
    #1;
  endtask

  task automatic edge_step();
    @(posedge clk);
    if (m_full && bus.out_ready) junk = sb.pop_front();
    if (exp_r1) begin sb.push_back({1'b0, bus.data1}); m_ptr = 1'b1; end
    if (exp_r2) begin sb.push_back({1'b1, bus.data2}); m_ptr = 1'b0; end
    m_full = (sb.size() != 0);
    #1;
  endtask

  task automatic do_reset();
    bus.valid1 = 1'b0; bus.valid2 = 1'b0; bus.out_ready = 1'b0;
    bus.data1 = 32'h0; bus.data2 = 32'h0;
    exp_r1 = 1'b0; exp_r2 = 1'b0;
    rst_n = 1'b0;
    sb.delete();
    m_full = 1'b0;
    m_ptr  = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.valid1 = 1'b1; bus.data1 = 32'h5;
    bus.valid2 = 1'b1; bus.data2 = 32'h6;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    vec++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.out_sel !== 1'b0 ||
        bus.ready1 !== 1'b0 || bus.ready2 !== 1'b0) begin
      err++;
      $display("FAIL reset: got v=%b d=%h s=%b r1=%b r2=%b, want all zero",
               bus.out_valid, bus.out_data, bus.out_sel, bus.ready1, bus.ready2);
    end
    do_reset();
  endtask

  task automatic test_single();
    do_reset();
    drive(1'b1, 32'h7, 1'b0, 32'h0, 1'b1);
    vec++;
    if (bus.ready1 !== 1'b1 || bus.ready2 !== 1'b0) begin
      err++; $display("FAIL single_ready: got r1=%b r2=%b want 1 0", bus.ready1, bus.ready2);
    end
    edge_step();
    vec++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h7 || bus.out_sel !== 1'b0 ||
        sb.size() != 1 || bus.out_data !== sb[0][N-1:0]) begin
      err++; $display("FAIL single_out: got v=%b d=%h s=%b want 1 7 0",
                      bus.out_valid, bus.out_data, bus.out_sel);
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    edge_step();
    vec++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h7 || sb.size() != 0) begin
      err++; $display("FAIL drain_empty: got v=%b d=%h want 0 7", bus.out_valid, bus.out_data);
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] want_d;
    logic         want_s;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      want_s = (i % 2 == 1);
      want_d = want_s ? 32'd2 : 32'd1;
      drive(1'b1, 32'd1, 1'b1, 32'd2, 1'b1);
      vec++;
      if (bus.ready1 !== ~want_s || bus.ready2 !== want_s || bus.ready1 !== exp_r1) begin
        err++; $display("FAIL rr_ready[%0d]: got r1=%b r2=%b want r2=%b", i,
                        bus.ready1, bus.ready2, want_s);
      end
      edge_step();
      vec++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== want_d || bus.out_sel !== want_s ||
          bus.out_data !== sb[0][N-1:0] || bus.out_sel !== sb[0][N]) begin
        err++; $display("FAIL rr_out[%0d]: got d=%h s=%b want d=%h s=%b", i,
                        bus.out_data, bus.out_sel, want_d, want_s);
      end
    end
  endtask

  task automatic test_hold_and_drain();
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b1, 32'hAA, 1'b0);
      vec++;
      if (bus.ready2 !== (i == 0) || bus.ready1 !== 1'b0) begin
        err++; $display("FAIL hold_ready[%0d]: got r2=%b want %b", i, bus.ready2, (i == 0));
      end
      edge_step();
      vec++;
      if (bus.out_valid !== 1'b1 || bus.out_data !== 32'hAA || bus.out_sel !== 1'b1) begin
        err++; $display("FAIL hold_out[%0d]: got v=%b d=%h s=%b want 1 aa 1", i,
                        bus.out_valid, bus.out_data, bus.out_sel);
      end
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    edge_step();
    vec++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'hAA || bus.out_sel !== 1'b1) begin
      err++; $display("FAIL drain_hold: got v=%b d=%h s=%b want 0 aa 1",
                      bus.out_valid, bus.out_data, bus.out_sel);
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    drive(1'b1, 32'h1234, 1'b0, 32'h0, 1'b0);
    edge_step();
    vec++;
    if (bus.out_valid !== 1'b1 || bus.out_data !== 32'h1234) begin
      err++; $display("FAIL areset_pre: got v=%b d=%h want 1 1234", bus.out_valid, bus.out_data);
    end
    bus.out_ready = 1'b1;
    #2;
    rst_n = 1'b0;
    #1;
    vec++;
    if (bus.out_valid !== 1'b0 || bus.out_data !== 32'h0 || bus.ready1 !== 1'b0) begin
      err++; $display("FAIL areset_now: got v=%b d=%h r1=%b want 0 0 0",
                      bus.out_valid, bus.out_data, bus.ready1);
    end
    do_reset();
  endtask

  task automatic test_back_to_back();
    logic         v1, v2, ordy;
    logic [N-1:0] d1, d2;
    do_reset();
    for (int i = 0; i < 80; i++) begin
      v1   = 1'($urandom_range(0, 1));
      v2   = 1'($urandom_range(0, 1));
      ordy = ($urandom_range(0, 3) != 0);
      d1   = $urandom;
      d2   = $urandom;
      drive(v1, d1, v2, d2, ordy);
      vec++;
      if (bus.ready1 !== exp_r1 || bus.ready2 !== exp_r2) begin
        err++; $display("FAIL b2b_ready[%0d]: got r1=%b r2=%b want %b %b", i,
                        bus.ready1, bus.ready2, exp_r1, exp_r2);
      end
      edge_step();
      vec++;
      if (sb.size() == 0) begin
        if (bus.out_valid !== 1'b0) begin
          err++; $display("FAIL b2b_empty[%0d]: got v=%b want 0", i, bus.out_valid);
        end
      end else if (bus.out_valid !== 1'b1 || bus.out_data !== sb[0][N-1:0] ||
                   bus.out_sel !== sb[0][N]) begin
        err++; $display("FAIL b2b_out[%0d]: got v=%b d=%h s=%b want 1 %h %b", i,
                        bus.out_valid, bus.out_data, bus.out_sel, sb[0][N-1:0], sb[0][N]);
      end
    end
  endtask

`ifdef ARB2TO1_CNT_EN
  task automatic test_counters();
    do_reset();
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'(i), 1'b0, 32'h0, 1'b1);
      edge_step();
    end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 32'h0, 1'b1, 32'(i), 1'b1);
      edge_step();
    end
    drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1);
    edge_step();
    vec++;
    if (bus.gnt_cnt1 !== 16'd5 || bus.gnt_cnt2 !== 16'd3) begin
      err++; $display("FAIL cnt: got %0d %0d want 5 3", bus.gnt_cnt1, bus.gnt_cnt2);
    end
    force dut.cnt1_r = 16'hFFFF;
    #1;
    release dut.cnt1_r;
    drive(1'b1, 32'h9, 1'b0, 32'h0, 1'b1);
    edge_step();
    vec++;
    if (bus.gnt_cnt1 !== 16'hFFFF || bus.gnt_cnt2 !== 16'd3) begin
      err++; $display("FAIL cnt_sat: got %h %0d want ffff 3", bus.gnt_cnt1, bus.gnt_cnt2);
    end
  endtask
`endif

  initial begin
    m_full = 1'b0;
    m_ptr  = 1'b0;
    exp_r1 = 1'b0;
    exp_r2 = 1'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_hold_and_drain();
    test_async_reset();
    test_back_to_back();
`ifdef ARB2TO1_CNT_EN
    test_counters();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule
